// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, access sizes,
// load funct3 encodings, exception causes and FSM states.
package memory_stage_pkg;

    localparam int unsigned DW = 64;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Access size taken from funct3[1:0]
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Low log2(size) address bits must be zero
    function automatic logic is_misaligned(input size_e sz, input logic [2:0] lane);
        logic mis;
        unique case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lane[0];
            SZ_W:    mis = |lane[1:0];
            default: mis = |lane;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Byte-lane alignment for the MEM stage.
//   funct3       : access size / signedness
//   lane         : byte offset within the doubleword
//   store_data   : raw store operand
//   rdata        : doubleword returned by data memory
//   wdata_c      : store data shifted into its byte lanes
//   wstrb_c      : byte enables for the store
//   load_data_c  : load data shifted down and sign/zero-extended
module memory_stage_mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]    funct3,
    input  logic [2:0]    lane,
    input  logic [DW-1:0] store_data,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] wdata_c,
    output logic [7:0]    wstrb_c,
    output logic [DW-1:0] load_data_c
);

    logic [DW-1:0] shifted;
    size_e         size;

    assign size = size_e'(funct3[1:0]);

    // Store side: shift data and strobes up to the addressed lane
    always_comb begin
        wdata_c = store_data << {lane, 3'b000};
        wstrb_c = 8'h00;
        unique case (size)
            SZ_B:    wstrb_c = 8'h01 << lane;
            SZ_H:    wstrb_c = 8'h03 << lane;
            SZ_W:    wstrb_c = 8'h0F << lane;
            default: wstrb_c = 8'hFF;
        endcase
    end

    // Load side: bring the addressed bytes to bit 0, then extend
    always_comb begin
        shifted     = rdata >> {lane, 3'b000};
        load_data_c = shifted;
        unique case (funct3)
            F3_LB:   load_data_c = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   load_data_c = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data_c = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   load_data_c = shifted;
            F3_LBU:  load_data_c = {56'd0, shifted[7:0]};
            F3_LHU:  load_data_c = {48'd0, shifted[15:0]};
            F3_LWU:  load_data_c = {32'd0, shifted[31:0]};
            default: load_data_c = shifted;  // funct3 7 behaves as LD
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV64 MEM pipeline stage: issues loads/stores to a single-port data memory
// over a req/ready handshake, stalls execute while an access is outstanding,
// and registers the WB_* latches for writeback.
//   clk, reset          : clock, asynchronous active-low reset
//   MEM_*               : pipeline latches from execute
//   MEM_stall           : freeze request to execute
//   dmem_*              : data memory request / response
//   WB_*                : registered latches for writeback, incl. exception
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned XLEN           = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MEM_V,
    input  logic [31:0]     MEM_IR,
    input  logic [XLEN-1:0] MEM_PC,
    input  logic [XLEN-1:0] MEM_ALU_RESULT,
    input  logic [XLEN-1:0] MEM_SR2,
    input  logic [XLEN-1:0] MEM_CSRFD,
    input  logic [XLEN-1:0] MEM_RFD,
    input  logic            MEM_ECALL,
    output logic            MEM_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            WB_V,
    output logic            WB_ECALL,
    output logic [31:0]     WB_IR,
    output logic [XLEN-1:0] WB_PC,
    output logic [XLEN-1:0] WB_ALU_RESULT,
    output logic [XLEN-1:0] WB_CSRFD,
    output logic [XLEN-1:0] WB_RFD,
    output logic [XLEN-1:0] WB_MEM_RESULT,
    output logic            WB_EXC,
    output logic [3:0]      WB_EXC_CAUSE
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    logic [2:0]      funct3;
    logic [2:0]      lane;
    logic            is_load, is_store, memop, misaligned;
    logic            timeout_c, req_c, stall_c, load_done_c, exc_c;
    logic [3:0]      cause_c;
    logic [XLEN-1:0] load_data;

    // Instruction decode
    assign funct3     = MEM_IR[14:12];
    assign lane       = MEM_ALU_RESULT[2:0];
    assign is_load    = (MEM_IR[6:0] == OPC_LOAD);
    assign is_store   = (MEM_IR[6:0] == OPC_STORE);
    assign memop      = is_load | is_store;
    assign misaligned = is_misaligned(size_e'(funct3[1:0]), lane);

    // Handshake and stall; the request is suppressed while reset is held
    assign timeout_c = (state == ST_WAIT) && (cnt == CNT_LAST) && !dmem_ready;

    always_comb begin
        req_c = 1'b0;
        if (state == ST_IDLE) begin
            req_c = MEM_V & memop & ~misaligned;
        end else begin
            req_c = 1'b1;
        end
        req_c = req_c & reset;
    end

    assign stall_c = reset &
                     (((state == ST_IDLE) & req_c & ~dmem_ready) |
                      ((state == ST_WAIT) & ~dmem_ready & ~timeout_c));

    assign load_done_c = req_c & dmem_ready & is_load;
    assign exc_c       = MEM_V & memop & (misaligned | timeout_c);
    assign cause_c     = is_load ? (timeout_c ? CAUSE_LOAD_FAULT  : CAUSE_LOAD_MISALIGNED)
                                 : (timeout_c ? CAUSE_STORE_FAULT : CAUSE_STORE_MISALIGNED);

    assign MEM_stall = stall_c;
    assign dmem_req  = req_c;
    assign dmem_we   = is_store;
    assign dmem_addr = {MEM_ALU_RESULT[XLEN-1:3], 3'b000};

    memory_stage_mem_align u_mem_align (
        .funct3      (funct3),
        .lane        (lane),
        .store_data  (MEM_SR2),
        .rdata       (dmem_rdata),
        .wdata_c     (dmem_wdata),
        .wstrb_c     (dmem_wstrb),
        .load_data_c (load_data)
    );

    // Next state and timeout counter
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_c && !dmem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_ready || timeout_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // WB latches: bubble while stalled, otherwise capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WB_V          <= 1'b0;
            WB_ECALL      <= 1'b0;
            WB_IR         <= '0;
            WB_PC         <= '0;
            WB_ALU_RESULT <= '0;
            WB_CSRFD      <= '0;
            WB_RFD        <= '0;
            WB_MEM_RESULT <= '0;
            WB_EXC        <= 1'b0;
            WB_EXC_CAUSE  <= '0;
        end else if (stall_c) begin
            WB_V <= 1'b0;
        end else begin
            WB_V          <= MEM_V;
            WB_ECALL      <= MEM_ECALL;
            WB_IR         <= MEM_IR;
            WB_PC         <= MEM_PC;
            WB_ALU_RESULT <= MEM_ALU_RESULT;
            WB_CSRFD      <= MEM_CSRFD;
            WB_RFD        <= MEM_RFD;
            WB_EXC        <= exc_c;
            WB_EXC_CAUSE  <= exc_c ? cause_c : 4'd0;
            if (load_done_c) begin
                WB_MEM_RESULT <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed test-plan steps followed by
// randomized loads/stores/ALU ops checked against a byte-level reference model.
module tb_memory_stage;

    localparam int T = 8;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_V;
    logic [31:0] MEM_IR;
    logic [63:0] MEM_PC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD;
    logic        MEM_ECALL;
    logic        MEM_stall;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;
    logic        WB_V, WB_ECALL;
    logic [31:0] WB_IR;
    logic [63:0] WB_PC, WB_ALU_RESULT, WB_CSRFD, WB_RFD, WB_MEM_RESULT;
    logic        WB_EXC;
    logic [3:0]  WB_EXC_CAUSE;

    int checks = 0;
    int errors = 0;

    // Model state for WB fields that hold between updates
    logic [63:0] exp_res;
    logic [63:0] exp_pc;

    memory_stage #(.TIMEOUT_CYCLES(T), .XLEN(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .MEM_V          (MEM_V),
        .MEM_IR         (MEM_IR),
        .MEM_PC         (MEM_PC),
        .MEM_ALU_RESULT (MEM_ALU_RESULT),
        .MEM_SR2        (MEM_SR2),
        .MEM_CSRFD      (MEM_CSRFD),
        .MEM_RFD        (MEM_RFD),
        .MEM_ECALL      (MEM_ECALL),
        .MEM_stall      (MEM_stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .WB_V           (WB_V),
        .WB_ECALL       (WB_ECALL),
        .WB_IR          (WB_IR),
        .WB_PC          (WB_PC),
        .WB_ALU_RESULT  (WB_ALU_RESULT),
        .WB_CSRFD       (WB_CSRFD),
        .WB_RFD         (WB_RFD),
        .WB_MEM_RESULT  (WB_MEM_RESULT),
        .WB_EXC         (WB_EXC),
        .WB_EXC_CAUSE   (WB_EXC_CAUSE)
    );

    always #5 clk = ~clk;

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {32'($urandom()), 32'($urandom())};
    endfunction

    function automatic logic [31:0] make_ir(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] ir;
        ir        = 32'($urandom());
        ir[6:0]   = op;
        ir[14:12] = f3;
        return ir;
    endfunction

    // Gather the addressed bytes, then extend according to funct3
    function automatic logic [63:0] load_model(input logic [2:0] f3, input int lane,
                                               input logic [63:0] rd);
        int n;
        logic [63:0] v;
        n = 1 << int'(f3[1:0]);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(lane+k) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1]) begin
            for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic set_misc();
        MEM_PC    = rnd64();
        MEM_CSRFD = rnd64();
        MEM_RFD   = rnd64();
        MEM_ECALL = 1'($urandom_range(0, 1));
    endtask

    task automatic check_commit(input logic v, input logic exc, input logic [3:0] cause);
        chk1 ("wb_v",          WB_V, v);
        chk1 ("wb_exc",        WB_EXC, exc);
        chk64("wb_exc_cause",  64'(WB_EXC_CAUSE), exc ? 64'(cause) : 64'd0);
        chk64("wb_pc",         WB_PC, MEM_PC);
        chk64("wb_alu_result", WB_ALU_RESULT, MEM_ALU_RESULT);
        chk64("wb_ir",         64'(WB_IR), 64'(MEM_IR));
        chk64("wb_csrfd",      WB_CSRFD, MEM_CSRFD);
        chk64("wb_rfd",        WB_RFD, MEM_RFD);
        chk1 ("wb_ecall",      WB_ECALL, MEM_ECALL);
        chk64("wb_mem_result", WB_MEM_RESULT, exp_res);
        exp_pc = MEM_PC;
    endtask

    // Non-memory instruction: never requests or stalls, even with stray ready
    task automatic run_alu(input logic v);
        MEM_V          = v;
        MEM_IR         = make_ir(OP_ADD, 3'($urandom_range(0, 7)));
        MEM_ALU_RESULT = rnd64();
        MEM_SR2        = rnd64();
        set_misc();
        dmem_ready     = 1'($urandom_range(0, 1));
        dmem_rdata     = rnd64();
        @(negedge clk);
        chk1("alu_dmem_req",  dmem_req, 1'b0);
        chk1("alu_mem_stall", MEM_stall, 1'b0);
        @(posedge clk); #1;
        check_commit(v, 1'b0, 4'd0);
        dmem_ready = 1'b0;
    endtask

    // Memory access; ready arrives in cycle d (0 = same cycle), d > T means never
    task automatic run_mem(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] sr2, input logic [63:0] rdata,
                           input int d, input logic v);
        int n, lane, stall_n;
        logic mis, issue, fault, exc;
        logic [3:0]  cause;
        logic [7:0]  strb;
        logic [63:0] wd;
        n       = 1 << int'(f3[1:0]);
        lane    = int'(addr[2:0]);
        mis     = (lane % n) != 0;
        issue   = v && !mis;
        fault   = issue && (d > T);
        stall_n = !issue ? 0 : ((d > T) ? T : d);
        exc     = v && (mis || fault);
        cause   = st ? (mis ? 4'd6 : 4'd7) : (mis ? 4'd4 : 4'd5);
        strb    = '0;
        wd      = '0;
        for (int b = 0; b < 8; b++) begin
            if (b >= lane && b < lane + n) strb[b] = 1'b1;
            if (b >= lane) wd[8*b +: 8] = sr2[8*(b-lane) +: 8];
        end

        MEM_V          = v;
        MEM_IR         = make_ir(st ? OP_STORE : OP_LOAD, f3);
        MEM_ALU_RESULT = addr;
        MEM_SR2        = sr2;
        set_misc();

        for (int i = 0; i <= stall_n; i++) begin
            dmem_ready = (i == d);
            dmem_rdata = rdata;
            @(negedge clk);
            chk1("dmem_req",  dmem_req, issue);
            chk1("mem_stall", MEM_stall, i < stall_n);
            if (i == 0 && issue) begin
                chk64("dmem_addr", dmem_addr, {addr[63:3], 3'b000});
                chk1 ("dmem_we",   dmem_we, st);
                if (st) begin
                    chk64("dmem_wstrb", 64'(dmem_wstrb), 64'(strb));
                    chk64("dmem_wdata", dmem_wdata, wd);
                end
            end
            @(posedge clk); #1;
            if (i < stall_n) begin
                chk1 ("wb_bubble",  WB_V, 1'b0);
                chk64("wb_pc_hold", WB_PC, exp_pc);
            end else begin
                if (issue && !fault && !st) exp_res = load_model(f3, lane, rdata);
                check_commit(v, exc, cause);
            end
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d;
        logic st;
        logic [2:0] f3;
        logic [63:0] addr;

        // Reset held with a valid aligned store presented: nothing may issue
        reset          = 1'b0;
        MEM_V          = 1'b1;
        MEM_IR         = make_ir(OP_STORE, 3'd3);
        MEM_ALU_RESULT = 64'h8000;
        MEM_SR2        = rnd64();
        set_misc();
        dmem_ready     = 1'b0;
        dmem_rdata     = '0;
        exp_res        = '0;
        exp_pc         = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1 ("rst_dmem_req",  dmem_req, 1'b0);
        chk1 ("rst_mem_stall", MEM_stall, 1'b0);
        chk1 ("rst_wb_v",      WB_V, 1'b0);
        chk1 ("rst_wb_exc",    WB_EXC, 1'b0);
        chk64("rst_wb_pc",     WB_PC, 64'd0);
        chk64("rst_wb_result", WB_MEM_RESULT, 64'd0);
        MEM_V = 1'b0;
        reset = 1'b1;

        // SD, zero-wait
        run_mem(1'b1, 3'd3, 64'h1000, 64'h1122334455667788, 64'd0, 0, 1'b1);
        // LB / LBU from lane 3 with one wait cycle
        run_mem(1'b0, 3'd0, 64'h1003, rnd64(), 64'h0000000080000000, 1, 1'b1);
        chk64("lb_result", WB_MEM_RESULT, 64'hFFFFFFFFFFFFFF80);
        run_mem(1'b0, 3'd4, 64'h1003, rnd64(), 64'h0000000080000000, 1, 1'b1);
        chk64("lbu_result", WB_MEM_RESULT, 64'h0000000000000080);
        // SH into the top halfword
        run_mem(1'b1, 3'd1, 64'h2006, 64'hABCD, 64'd0, 0, 1'b1);
        chk64("sh_wstrb", 64'(dmem_wstrb), 64'hC0);
        chk64("sh_wdata_hi", 64'(dmem_wdata[63:48]), 64'hABCD);
        // Misaligned LW with a stray ready
        run_mem(1'b0, 3'd2, 64'h3002, rnd64(), rnd64(), 0, 1'b1);
        // SW that never completes
        run_mem(1'b1, 3'd2, 64'h4000, rnd64(), 64'd0, T + 100, 1'b1);
        chk64("timeout_cause", 64'(WB_EXC_CAUSE), 64'd7);
        run_alu(1'b1);
        // Ready on the last cycle before timeout, and one cycle too late
        run_mem(1'b0, 3'd3, 64'h5008, rnd64(), rnd64(), T, 1'b1);
        run_mem(1'b0, 3'd3, 64'h5010, rnd64(), rnd64(), T + 1, 1'b1);
        // Valid=0 memop never issues
        run_mem(1'b0, 3'd3, 64'h6000, rnd64(), rnd64(), 0, 1'b0);

        // Reset while waiting on a store
        MEM_V          = 1'b1;
        MEM_IR         = make_ir(OP_STORE, 3'd3);
        MEM_ALU_RESULT = 64'h7000;
        set_misc();
        dmem_ready     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("pre_reset_stall", MEM_stall, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1 ("async_rst_dmem_req",  dmem_req, 1'b0);
        chk1 ("async_rst_mem_stall", MEM_stall, 1'b0);
        chk1 ("async_rst_wb_v",      WB_V, 1'b0);
        chk64("async_rst_wb_pc",     WB_PC, 64'd0);
        chk64("async_rst_wb_result", WB_MEM_RESULT, 64'd0);
        @(posedge clk); #1;
        reset   = 1'b1;
        exp_res = '0;
        exp_pc  = '0;
        run_alu(1'b1);

        // Randomized mix
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 2) begin
                run_alu(1'($urandom_range(0, 1)));
            end else begin
                st   = 1'($urandom_range(0, 1));
                f3   = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                addr = rnd64();
                if ($urandom_range(0, 3) != 0) begin
                    addr = addr & ~64'((1 << int'(f3[1:0])) - 1);
                end
                case ($urandom_range(0, 4))
                    0:       d = 0;
                    1:       d = 1;
                    2:       d = 2;
                    3:       d = int'($urandom_range(3, T));
                    default: d = T + 1 + int'($urandom_range(0, 3));
                endcase
                run_mem(st, f3, addr, rnd64(), rnd64(), d, 1'($urandom_range(0, 7) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
